// File: rtl/cpu_reg_package.sv
// Shared CPU-bus region description used by bus wait/CDC blocks.
// Holds the region mode and FSM encodings plus the per-region config record.
package cpu_reg_package;

  localparam int REGION_ADDR_W = 64;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    FIXED = 2'd1,
    BUSY  = 2'd2,
    RSVD  = 2'd3
  } bus_wait_mode_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIXED = 2'd1,
    WAIT_BUSY  = 2'd2,
    DONE       = 2'd3
  } bus_wait_state_t;

  typedef struct packed {
    logic [REGION_ADDR_W-1:0] start_addr;
    logic [REGION_ADDR_W-1:0] end_addr;
    bus_wait_mode_t           mode;
    logic [3:0]               latency;
  } region_cfg_t;

  // RSVD behaves as passthrough, so only FIXED and BUSY ever stall the CPU.
  function automatic logic mode_stalls(input bus_wait_mode_t m);
    return (m == FIXED) || (m == BUSY);
  endfunction

endpackage

// File: rtl/bus_region_decode.sv
// Combinational priority decoder: inclusive start/end windows, lowest index wins.
module bus_region_decode #(
  parameter int                                NUM_REGIONS  = 4,
  parameter int                                ADDR_WIDTH   = 32,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_START = '0,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_END   = '0
) (
  input  logic [ADDR_WIDTH-1:0]          address,
  output logic                           hit,
  output logic [$clog2(NUM_REGIONS)-1:0] hit_idx
);

  localparam int IDX_W = $clog2(NUM_REGIONS);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (address >= REGION_START[r*ADDR_WIDTH +: ADDR_WIDTH] &&
          address <= REGION_END[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(r);
      end
    end
  end

endmodule

// File: rtl/bus_wait_ctrl.sv
// Multi-region CPU bus wait-state controller: passthrough, fixed-latency or
// busy-handshake regions with a watchdog that returns ERROR_WORD on expiry.
module bus_wait_ctrl
  import cpu_reg_package::*;
#(
  parameter int                                NUM_REGIONS    = 4,
  parameter int                                ADDR_WIDTH     = 32,
  parameter int                                DATA_WIDTH     = 32,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_START   = '0,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_END     = '0,
  parameter logic [NUM_REGIONS*2-1:0]          REGION_MODE    = '0,
  parameter logic [NUM_REGIONS*4-1:0]          REGION_LATENCY = '0,
  parameter int                                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0]             ERROR_WORD     = 32'hDEAD_BEEF
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [ADDR_WIDTH-1:0]             address_i,
  input  logic                              we_i,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_REGIONS-1:0]            module_busy_i,
  output logic [NUM_REGIONS-1:0]            sel_o,
  output logic                              busy_o,
  output logic [DATA_WIDTH-1:0]             data_o,
  output logic                              timeout_o,
  output logic [$clog2(NUM_REGIONS)-1:0]    timeout_region_o
);

  localparam int IDX_W = $clog2(NUM_REGIONS);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  function automatic region_cfg_t cfg_of(input logic [IDX_W-1:0] r);
    region_cfg_t c;
    c.start_addr = REGION_ADDR_W'(REGION_START[int'(r)*ADDR_WIDTH +: ADDR_WIDTH]);
    c.end_addr   = REGION_ADDR_W'(REGION_END[int'(r)*ADDR_WIDTH +: ADDR_WIDTH]);
    c.mode       = bus_wait_mode_t'(REGION_MODE[int'(r)*2 +: 2]);
    c.latency    = REGION_LATENCY[int'(r)*4 +: 4];
    return c;
  endfunction

  bus_wait_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0]  address_q;
  logic [3:0]             cnt_q, cnt_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   busy_prev_q, busy_prev_d;
  logic [IDX_W-1:0]       region_q, region_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   timeout_q, timeout_d;
  logic [IDX_W-1:0]       timeout_region_q, timeout_region_d;

  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  region_cfg_t            hit_cfg;
  logic                   new_access, access, stall_mode;
  logic [DATA_WIDTH-1:0]  hit_dat, act_dat;
  logic                   unused_bits;

  bus_region_decode #(
    .NUM_REGIONS  (NUM_REGIONS),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .REGION_START (REGION_START),
    .REGION_END   (REGION_END)
  ) u_decode (
    .address (address_i),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  assign hit_cfg    = cfg_of(hit_idx);
  assign stall_mode = mode_stalls(hit_cfg.mode);
  assign new_access = (address_i != address_q);
  assign access     = !reset_i && (state_q == IDLE) && new_access && hit;
  assign hit_dat    = data_i[int'(hit_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign act_dat    = data_i[int'(region_q)*DATA_WIDTH +: DATA_WIDTH];

  // Writes stall exactly like reads; the direction never changes the timing.
  assign unused_bits = ^{we_i, hit_cfg.start_addr, hit_cfg.end_addr};

  assign sel_o  = access ? (NUM_REGIONS'(1) << hit_idx) : '0;
  assign busy_o = !reset_i && ((access && stall_mode) ||
                               (state_q == WAIT_FIXED) || (state_q == WAIT_BUSY));
  assign data_o           = data_q;
  assign timeout_o        = timeout_q;
  assign timeout_region_o = timeout_region_q;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    wd_d             = wd_q;
    busy_prev_d      = busy_prev_q;
    region_d         = region_q;
    data_d           = data_q;
    timeout_d        = 1'b0;
    timeout_region_d = timeout_region_q;
    unique case (state_q)
      IDLE: begin
        if (!hit) begin
          data_d = '0;
        end else if (!stall_mode) begin
          data_d = hit_dat;
        end else if (new_access) begin
          region_d = hit_idx;
          if (hit_cfg.mode == FIXED) begin
            // The detect cycle counts as the first wait cycle, so L=0 finishes at once.
            if (hit_cfg.latency == 4'd0) begin
              data_d  = hit_dat;
              state_d = DONE;
            end else begin
              cnt_d   = hit_cfg.latency - 4'd1;
              state_d = WAIT_FIXED;
            end
          end else begin
            wd_d        = '0;
            busy_prev_d = module_busy_i[hit_idx];
            state_d     = WAIT_BUSY;
          end
        end
      end
      WAIT_FIXED: begin
        if (cnt_q == 4'd0) begin
          data_d  = act_dat;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WAIT_BUSY: begin
        busy_prev_d = module_busy_i[region_q];
        // A falling edge beats a watchdog expiry in the same cycle.
        if (busy_prev_q && !module_busy_i[region_q]) begin
          data_d  = act_dat;
          state_d = DONE;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          data_d           = ERROR_WORD;
          timeout_d        = 1'b1;
          timeout_region_d = region_q;
          state_d          = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      address_q        <= '0;
      cnt_q            <= '0;
      wd_q             <= '0;
      busy_prev_q      <= 1'b0;
      region_q         <= '0;
      data_q           <= '0;
      timeout_q        <= 1'b0;
      timeout_region_q <= '0;
    end else begin
      state_q          <= state_d;
      address_q        <= address_i;
      cnt_q            <= cnt_d;
      wd_q             <= wd_d;
      busy_prev_q      <= busy_prev_d;
      region_q         <= region_d;
      data_q           <= data_d;
      timeout_q        <= timeout_d;
      timeout_region_q <= timeout_region_d;
    end
  end

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Randomized and directed bench for bus_wait_ctrl against a stall/data model.
module tb_bus_wait_ctrl;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [AW-1:0] address_i;
  logic          we_i;
  logic [NR*DW-1:0] data_i;
  logic [NR-1:0] module_busy_i;
  logic [NR-1:0] sel_o;
  logic          busy_o;
  logic [DW-1:0] data_o;
  logic          timeout_o;
  logic [1:0]    timeout_region_o;

  bus_wait_ctrl #(
    .NUM_REGIONS    (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .REGION_START   ({32'h300, 32'h200, 32'h080, 32'h000}),
    .REGION_END     ({32'h3FF, 32'h2FF, 32'h1FF, 32'h0FF}),
    .REGION_MODE    ({2'd1, 2'd2, 2'd1, 2'd0}),
    .REGION_LATENCY ({4'd0, 4'd0, 4'd3, 4'd0}),
    .TIMEOUT_CYCLES (TO),
    .ERROR_WORD     (32'hDEAD_BEEF)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .address_i        (address_i),
    .we_i             (we_i),
    .data_i           (data_i),
    .module_busy_i    (module_busy_i),
    .sel_o            (sel_o),
    .busy_o           (busy_o),
    .data_o           (data_o),
    .timeout_o        (timeout_o),
    .timeout_region_o (timeout_region_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference region map: lowest matching index wins.
  logic [31:0] m_start [4] = '{32'h000, 32'h080, 32'h200, 32'h300};
  logic [31:0] m_end   [4] = '{32'h0FF, 32'h1FF, 32'h2FF, 32'h3FF};
  int          m_mode  [4] = '{0, 1, 2, 1};
  int          m_lat   [4] = '{0, 3, 0, 0};
  logic [1:0]  m_last_to = 2'd0;
  logic [31:0] last_addr = 32'h0;

  function automatic int model_region(input logic [31:0] a);
    for (int r = 0; r < 4; r++)
      if (a >= m_start[r] && a <= m_end[r]) return r;
    return -1;
  endfunction

  // A handshake completes only if the falling edge arrives no later than cycle T+TO.
  function automatic bit model_timed_out(input int mode, input int k);
    return (mode == 2) && !(k >= 1 && k + 1 <= TO);
  endfunction

  function automatic int model_stall(input int mode, input int lat, input int k);
    if (mode == 1) return lat + 1;
    if (mode == 2) return model_timed_out(mode, k) ? TO + 1 : k + 2;
    return 0;
  endfunction

  // Presents one access; the target's busy line is high for cycles T+1..T+k.
  task automatic drive_access(input logic [31:0] addr, input int k, input logic [NR*DW-1:0] din,
                              output logic [NR-1:0] sel_seen, output int stall,
                              output logic [DW-1:0] dout, output int to_cnt);
    int c;
    @(posedge clk_i); #1;
    address_i = addr;
    data_i = din;
    module_busy_i = '0;
    last_addr = addr;
    @(negedge clk_i);
    sel_seen = sel_o;
    stall = 0;
    c = 0;
    to_cnt = int'(timeout_o);
    while (busy_o && stall < 200) begin
      stall++;
      c++;
      @(posedge clk_i); #1;
      module_busy_i = (c >= 1 && c <= k) ? '1 : '0;
      @(negedge clk_i);
      to_cnt += int'(timeout_o);
    end
    if (stall == 0) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      to_cnt += int'(timeout_o);
    end
    dout = data_o;
    module_busy_i = '0;
  endtask

  task automatic test_reset;
    reset_i = 1'b1; address_i = '0; we_i = 1'b0; data_i = '0; module_busy_i = '0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (sel_o !== 4'b0) begin errors++; $display("FAIL reset_sel: got %b expected 0000", sel_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_o); end
    checks++; if (timeout_o !== 1'b0 || timeout_region_o !== 2'd0) begin errors++;
      $display("FAIL reset_timeout: got %b/%0d expected 0/0", timeout_o, timeout_region_o); end
  endtask

  task automatic test_passthrough;
    logic [NR-1:0] s; int st, tc; logic [DW-1:0] d;
    drive_access(32'h010, 0, {96'h0, 32'h1234}, s, st, d, tc);
    checks++; if (st !== 0) begin errors++; $display("FAIL pass_stall: got %0d expected 0", st); end
    checks++; if (s !== 4'b0001) begin errors++; $display("FAIL pass_sel: got %b expected 0001", s); end
    checks++; if (d !== 32'h1234) begin errors++; $display("FAIL pass_data: got %h expected 1234", d); end
  endtask

  task automatic test_fixed;
    logic [NR-1:0] s; int st, tc; logic [DW-1:0] d;
    drive_access(32'h100, 0, {32'h0, 32'h0, 32'hCAFE_0001, 32'h0}, s, st, d, tc);
    checks++; if (st !== 4) begin errors++; $display("FAIL fixed_stall: got %0d expected 4", st); end
    checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL fixed_data: got %h expected cafe0001", d); end
    drive_access(32'h3A0, 0, {32'h3333_0000, 96'h0}, s, st, d, tc);
    checks++; if (st !== 1) begin errors++; $display("FAIL fixed_l0_stall: got %0d expected 1", st); end
    checks++; if (d !== 32'h3333_0000) begin errors++; $display("FAIL fixed_l0_data: got %h expected 33330000", d); end
  endtask

  task automatic test_handshake;
    logic [NR-1:0] s; int st, tc; logic [DW-1:0] d;
    int ks [3] = '{10, 15, 1};
    foreach (ks[i]) begin
      drive_access(32'h200 + 32'(i), ks[i], {32'h0, 32'hB0B0_0000 + 32'(i), 64'h0}, s, st, d, tc);
      checks++; if (st !== ks[i] + 2) begin errors++;
        $display("FAIL hs_stall k=%0d: got %0d expected %0d", ks[i], st, ks[i] + 2); end
      checks++; if (d !== 32'hB0B0_0000 + 32'(i) || tc !== 0) begin errors++;
        $display("FAIL hs_data k=%0d: got %h/%0d expected %h/0", ks[i], d, tc, 32'hB0B0_0000 + 32'(i)); end
    end
    checks++; if (s !== 4'b0100) begin errors++; $display("FAIL hs_sel: got %b expected 0100", s); end
  endtask

  task automatic test_timeout;
    logic [NR-1:0] s; int st, tc; logic [DW-1:0] d;
    drive_access(32'h2F0, 0, {32'h0, 32'h5555_5555, 64'h0}, s, st, d, tc);
    m_last_to = 2'd2;
    checks++; if (st !== TO + 1) begin errors++; $display("FAIL to_stall: got %0d expected %0d", st, TO + 1); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_data: got %h expected deadbeef", d); end
    checks++; if (tc !== 1) begin errors++; $display("FAIL to_pulses: got %0d expected 1", tc); end
    checks++; if (timeout_region_o !== 2'd2) begin errors++; $display("FAIL to_region: got %0d expected 2", timeout_region_o); end
  endtask

  task automatic test_overlap_unmapped;
    logic [NR-1:0] s; int st, tc; logic [DW-1:0] d;
    drive_access(32'h080, 0, {32'h0, 32'h0, 32'h1111, 32'h2222}, s, st, d, tc);
    checks++; if (s !== 4'b0001 || st !== 0) begin errors++; $display("FAIL overlap_sel: got %b/%0d expected 0001/0", s, st); end
    checks++; if (d !== 32'h2222) begin errors++; $display("FAIL overlap_data: got %h expected 2222", d); end
    drive_access(32'hF000, 0, {4{32'h7777}}, s, st, d, tc);
    checks++; if (s !== 4'b0 || st !== 0 || d !== 32'h0) begin errors++;
      $display("FAIL unmapped: got sel=%b stall=%0d data=%h expected 0000/0/0", s, st, d); end
  endtask

  task automatic test_reset_mid_wait;
    logic [NR-1:0] s; int st, tc; logic [DW-1:0] d;
    drive_access(32'h010, 0, {96'h0, 32'hABCD}, s, st, d, tc);
    @(posedge clk_i); #1;
    address_i = 32'h210; module_busy_i = '0;
    for (int c = 1; c <= 4; c++) begin @(posedge clk_i); #1; module_busy_i = '1; end
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_wait_busy: got %b expected 1", busy_o); end
    @(posedge clk_i); #1;
    reset_i = 1'b1; address_i = '0;
    @(posedge clk_i); #1;
    reset_i = 1'b0; module_busy_i = '0;
    last_addr = '0; m_last_to = 2'd0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || data_o !== 32'h0) begin errors++;
      $display("FAIL rst_mid: got busy=%b data=%h expected 0/0", busy_o, data_o); end
    checks++; if (timeout_region_o !== 2'd0) begin errors++; $display("FAIL rst_mid_region: got %0d expected 0", timeout_region_o); end
    drive_access(32'h104, 0, {32'h0, 32'h0, 32'h4242, 32'h0}, s, st, d, tc);
    checks++; if (st !== 4 || d !== 32'h4242) begin errors++;
      $display("FAIL rst_after: got stall=%0d data=%h expected 4/4242", st, d); end
  endtask

  task automatic test_random;
    logic [NR-1:0] s, es; int st, tc, k, r, cls, est; logic [DW-1:0] d, ed;
    logic [31:0] a; logic [NR*DW-1:0] din; bit tmo;
    for (int i = 0; i < 40; i++) begin
      do begin
        cls = $urandom_range(0, 4);
        if (cls == 4) a = $urandom_range(32'h400, 32'hFFFF);
        else a = m_start[cls] + $urandom_range(0, m_end[cls] - m_start[cls]);
      end while (a == last_addr);
      k = $urandom_range(0, 20);
      din = {$urandom, $urandom, $urandom, $urandom};
      we_i = 1'($urandom_range(0, 1));
      r = model_region(a);
      if (r < 0) begin es = '0; est = 0; ed = '0; tmo = 1'b0; end
      else begin
        es = 4'(1 << r);
        est = model_stall(m_mode[r], m_lat[r], k);
        tmo = model_timed_out(m_mode[r], k);
        ed = tmo ? 32'hDEAD_BEEF : din[r*DW +: DW];
        if (tmo) m_last_to = 2'(r);
      end
      drive_access(a, k, din, s, st, d, tc);
      checks++; if (s !== es) begin errors++; $display("FAIL rnd_sel a=%h: got %b expected %b", a, s, es); end
      checks++; if (st !== est) begin errors++; $display("FAIL rnd_stall a=%h k=%0d: got %0d expected %0d", a, k, st, est); end
      checks++; if (d !== ed) begin errors++; $display("FAIL rnd_data a=%h: got %h expected %h", a, d, ed); end
      checks++; if (tc !== int'(tmo) || timeout_region_o !== m_last_to) begin errors++;
        $display("FAIL rnd_timeout a=%h: got %0d/%0d expected %0d/%0d", a, tc, timeout_region_o, tmo, m_last_to); end
    end
    we_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_fixed();
    test_handshake();
    test_timeout();
    test_overlap_unmapped();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
